// File: rtl/dsp_pkg.sv
// Shared DSP-chain definitions for the multiplier-sharing block:
// widths, requester identities and an index-width helper.
package dsp_pkg;

    localparam int MULT_WIDTH = 16;
    localparam int N_MULT_REQ = 3;

    typedef enum {
        REQ_LFO = 0,
        REQ_MIX = 1,
        REQ_DLY = 2
    } mult_req_e;

    typedef logic signed [2*MULT_WIDTH-1:0] prod_t;

    // a single requester still needs a one-bit tag
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Requester-facing bus of the shared multiplier: requests and
// operands in, grants and tagged products out.
interface mult_share_arb_if
    import dsp_pkg::*;
#(
    parameter int N_REQ = N_MULT_REQ,
    parameter int WIDTH = MULT_WIDTH
);

    logic [N_REQ-1:0]             req_i;
    logic [N_REQ-1:0][WIDTH-1:0]  opA_i;
    logic [N_REQ-1:0][WIDTH-1:0]  opB_i;
    logic [N_REQ-1:0]             gnt_o;
    logic signed [2*WIDTH-1:0]    result_o;
    logic [N_REQ-1:0]             resultValid_o;
    logic                         busy_o;

    modport master (
        output req_i,
        output opA_i,
        output opB_i,
        input  gnt_o,
        input  result_o,
        input  resultValid_o,
        input  busy_o
    );

    modport slave (
        input  req_i,
        input  opA_i,
        input  opB_i,
        output gnt_o,
        output result_o,
        output resultValid_o,
        output busy_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin winner select with a registered last pointer; the
// registered grant masks its owner for one cycle.
module rr_arbiter
    import dsp_pkg::*;
#(
    parameter int N_REQ = N_MULT_REQ,
    parameter int TW    = idx_width(N_REQ)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             win_vld_o,
    output logic [TW-1:0]    win_o
);

    logic [TW-1:0]    last_q;
    logic [TW-1:0]    last_d;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] gnt_d;
    logic [N_REQ-1:0] req_m;
    logic             win_vld;
    logic [TW-1:0]    win;
    logic [TW-1:0]    idx;

    // a level still high in its own grant cycle is the old request
    assign req_m = req_i & ~gnt_q;

    always_comb begin
        win_vld = 1'b0;
        win     = last_q;
        idx     = last_q;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = TW'((int'(last_q) + i) % N_REQ);
            if (!win_vld && req_m[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        gnt_d  = '0;
        if (win_vld) begin
            last_d = win;
            gnt_d  = N_REQ'(1) << win;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= TW'(N_REQ - 1);
            gnt_q  <= '0;
        end else begin
            last_q <= last_d;
            gnt_q  <= gnt_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign win_vld_o = win_vld;
    assign win_o     = win;

endmodule

// File: rtl/mult_share_arb.sv
// Shares one signed WIDTHxWIDTH multiplier between N_REQ requesters:
// round-robin grant, operand capture, two-stage product pipeline.
module mult_share_arb
    import dsp_pkg::*;
#(
    parameter int N_REQ = N_MULT_REQ,
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic         clk_i,
    input  logic         reset_i,
    mult_share_arb_if.slave bus
);

    localparam int TW = idx_width(N_REQ);
    localparam int PW = 2 * WIDTH;

    logic             win_vld;
    logic [TW-1:0]    win;
    logic [N_REQ-1:0] gnt;

    logic             valid1_q;
    logic             valid1_d;
    logic [TW-1:0]    tag1_q;
    logic [TW-1:0]    tag1_d;
    logic [WIDTH-1:0] opa1_q;
    logic [WIDTH-1:0] opa1_d;
    logic [WIDTH-1:0] opb1_q;
    logic [WIDTH-1:0] opb1_d;

    logic             valid2_q;
    logic             valid2_d;
    logic [TW-1:0]    tag2_q;
    logic [TW-1:0]    tag2_d;
    logic [PW-1:0]    prod2_q;
    logic [PW-1:0]    prod2_d;

    logic [PW-1:0]    opa_ext;
    logic [PW-1:0]    opb_ext;
    logic [PW-1:0]    mul;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .TW    (TW)
    ) u_arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (bus.req_i),
        .gnt_o     (gnt),
        .win_vld_o (win_vld),
        .win_o     (win)
    );

    // sign-extend so the low PW bits are the exact signed product
    assign opa_ext = {{WIDTH{opa1_q[WIDTH-1]}}, opa1_q};
    assign opb_ext = {{WIDTH{opb1_q[WIDTH-1]}}, opb1_q};
    assign mul     = opa_ext * opb_ext;

    always_comb begin
        valid1_d = win_vld;
        tag1_d   = tag1_q;
        opa1_d   = opa1_q;
        opb1_d   = opb1_q;
        if (win_vld) begin
            tag1_d = win;
            opa1_d = bus.opA_i[win];
            opb1_d = bus.opB_i[win];
        end
    end

    always_comb begin
        valid2_d = valid1_q;
        tag2_d   = valid1_q ? tag1_q : tag2_q;
        prod2_d  = valid1_q ? mul : prod2_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid1_q <= 1'b0;
            tag1_q   <= '0;
            opa1_q   <= '0;
            opb1_q   <= '0;
        end else begin
            valid1_q <= valid1_d;
            tag1_q   <= tag1_d;
            opa1_q   <= opa1_d;
            opb1_q   <= opb1_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid2_q <= 1'b0;
            tag2_q   <= '0;
            prod2_q  <= '0;
        end else begin
            valid2_q <= valid2_d;
            tag2_q   <= tag2_d;
            prod2_q  <= prod2_d;
        end
    end

    assign bus.gnt_o         = gnt;
    assign bus.result_o      = prod2_q;
    assign bus.resultValid_o = valid2_q ? (N_REQ'(1) << tag2_q) : '0;
    assign bus.busy_o        = valid1_q | valid2_q;

endmodule
